// File: rtl/mem_access_seq.sv
// Memory-access sequencer: takes one fetch/load/store request at a time, runs the
// four-phase ramMFA/ramMFC handshake and returns extended load data or an error code.
module mem_access_seq #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_fetch,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic              ramMFA,
   output logic              ramRW,
   output logic [1:0]        ramDataSize,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [DATA_W-1:0] ramDataOut,
   input  logic [DATA_W-1:0] ramDataIn,
   input  logic              ramMFC,
   output logic [1:0]        dbg_state
);

   // Request side: req_valid is sampled only on an edge where req_ready is high;
   // the requester holds req_valid and the request fields until that edge.
   // RAM side: ramMFA rises with stable address/rw/size/data, RAM answers with
   // ramMFC, ramMFA falls, and a new access waits until ramMFC has fallen.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_RESP    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_err_q, rsp_err_d;
   logic                mfa_q, mfa_d;
   logic                rw_q, rw_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                sgn_q, sgn_d;

   logic [1:0]          eff_size;
   logic                eff_rw;
   logic                eff_sgn;
   logic [1:0]          chk_err;
   logic [DATA_W-1:0]   ext_data;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 2'b00;
      mfa_d       = mfa_q;
      rw_d        = rw_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      sgn_d       = sgn_q;

      eff_size = req_fetch ? 2'b10 : req_size;
      eff_rw   = ~req_fetch & req_rw;
      eff_sgn  = ~req_fetch & req_signed;

      // Illegal size outranks misalignment.
      if (eff_size == 2'b11)
         chk_err = 2'b11;
      else if ((eff_size == 2'b01 && req_addr[0]) ||
               (eff_size == 2'b10 && req_addr[1:0] != 2'b00))
         chk_err = 2'b01;
      else
         chk_err = 2'b00;

      case (size_q)
         2'b00:   ext_data = {{24{sgn_q & ramDataIn[7]}}, ramDataIn[7:0]};
         2'b01:   ext_data = {{16{sgn_q & ramDataIn[15]}}, ramDataIn[15:0]};
         default: ext_data = ramDataIn;
      endcase

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_ready_d = 1'b0;
               if (chk_err != 2'b00) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = chk_err;
               end else begin
                  state_d = S_ACCESS;
                  cnt_d   = '0;
                  mfa_d   = 1'b1;
                  rw_d    = eff_rw;
                  size_d  = eff_size;
                  sgn_d   = eff_sgn;
                  addr_d  = req_addr;
                  wdata_d = eff_rw ? req_wdata : '0;
               end
            end
         end
         S_ACCESS: begin
            // MFC arriving on the timeout edge still completes the access normally.
            if (ramMFC || cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ramMFC ? 2'b00 : 2'b10;
               rsp_rdata_d = (ramMFC && !rw_q) ? ext_data : '0;
               mfa_d       = 1'b0;
               rw_d        = 1'b0;
               size_d      = 2'b00;
               sgn_d       = 1'b0;
               addr_d      = '0;
               wdata_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (ramMFC) begin
               state_d = S_RELEASE;
            end else begin
               state_d     = S_IDLE;
               req_ready_d = 1'b1;
            end
         end
         S_RELEASE: begin
            if (!ramMFC) begin
               state_d     = S_IDLE;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 2'b00;
         mfa_q       <= 1'b0;
         rw_q        <= 1'b0;
         size_q      <= 2'b00;
         addr_q      <= '0;
         wdata_q     <= '0;
         sgn_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mfa_q       <= mfa_d;
         rw_q        <= rw_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         sgn_q       <= sgn_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign ramMFA      = mfa_q;
   assign ramRW       = rw_q;
   assign ramDataSize = size_q;
   assign ramAddress  = addr_q;
   assign ramDataOut  = wdata_q;
   assign dbg_state   = state_q;

endmodule
